// File: rtl/biriscv_mule.sv
// Iterative shift-add multiplier for the biRISC-V MULE instruction class (MUL/MULH/MULHSU/MULHU).
// Optional build macro MULE_EARLY_OUT_EN: a zero operand skips CALC and completes with result 0.
module biriscv_mule #(
    parameter int MULE_BITS_PER_CYCLE = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        hold_i,
    input  logic        flush_i,
    output logic        mule_busy_o,
    output logic        mule_complete_o,
    output logic [31:0] mule_result_o
);
    localparam int B  = MULE_BITS_PER_CYCLE;
    localparam int N  = 32 / B;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [63:0]   mcand_q;
    logic [31:0]   mplier_q;
    logic [63:0]   acc_q;
    logic [CW-1:0] count_q;
    logic          sign_q;
    logic          sel_hi_q;

    function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic is_signed);
        logic [31:0] r;
        r = v;
        if (is_signed && v[31])
            r = ~v + 32'd1;
        return r;
    endfunction

    function automatic logic [63:0] partial_product(input logic [63:0] m, input logic [B-1:0] d);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < B; i++)
            if (d[i])
                p = p + (m << i);
        return p;
    endfunction

    function automatic logic [63:0] apply_sign(input logic [63:0] p, input logic neg);
        return neg ? (~p + 64'd1) : p;
    endfunction

    logic [2:0]  funct3;
    logic        ra_signed;
    logic        rb_signed;
    logic        sel_hi;
    logic        ra_neg;
    logic        rb_neg;
    logic        can_accept;
    logic        accept;
    logic        zero_op;
    logic        last_iter;
    logic [63:0] sum;
    logic [63:0] product;
    logic        unused_opcode;

    assign funct3        = opcode_opcode_i[14:12];
    assign unused_opcode = ^{opcode_opcode_i[31:15], opcode_opcode_i[11:0]};
    // 1xx decodes as MULHU: neither operand signed, high half selected.
    assign ra_signed = !funct3[2] && (funct3[1:0] != 2'b11);
    assign rb_signed = !funct3[2] && !funct3[1];
    assign sel_hi    = (funct3 != 3'b000);
    assign ra_neg    = ra_signed && opcode_ra_operand_i[31];
    assign rb_neg    = rb_signed && opcode_rb_operand_i[31];

    assign can_accept = (state_q == IDLE) || ((state_q == DONE) && !hold_i);
    assign accept     = opcode_valid_i && !flush_i && can_accept;

`ifdef MULE_EARLY_OUT_EN
    assign zero_op = (opcode_ra_operand_i == 32'd0) || (opcode_rb_operand_i == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    assign last_iter = (state_q == CALC) && (count_q == LAST);
    assign sum       = acc_q + partial_product(mcand_q, mplier_q[B-1:0]);
    assign product   = apply_sign(sum, sign_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = zero_op ? DONE : CALC;
            CALC: if (last_iter) state_d = DONE;
            DONE: begin
                if (!hold_i)
                    state_d = accept ? (zero_op ? DONE : CALC) : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i)
            state_d = IDLE;
    end

    // The multiplicand shifts left and the multiplier right each iteration, so the
    // low digit of mplier_q is always the next one and mcand_q carries the digit weight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            count_q       <= '0;
            sign_q        <= 1'b0;
            sel_hi_q      <= 1'b0;
            mule_result_o <= '0;
        end else if (accept) begin
            mcand_q  <= {32'd0, magnitude($signed(opcode_ra_operand_i), ra_signed)};
            mplier_q <= magnitude($signed(opcode_rb_operand_i), rb_signed);
            acc_q    <= '0;
            count_q  <= '0;
            sign_q   <= ra_neg ^ rb_neg;
            sel_hi_q <= sel_hi;
            if (zero_op)
                mule_result_o <= '0;
        end else if (state_q == CALC) begin
            acc_q    <= sum;
            mcand_q  <= mcand_q << B;
            mplier_q <= mplier_q >> B;
            count_q  <= count_q + 1'b1;
            if (last_iter && !flush_i)
                mule_result_o <= sel_hi_q ? product[63:32] : product[31:0];
        end
    end

    assign mule_busy_o     = (state_q != IDLE);
    assign mule_complete_o = (state_q == DONE);

endmodule
